// File: rtl/flash_loader_top.sv
// Boot-time loader: copies a block of SPI NOR flash (READ 0x03) into a small
// burst RAM, then cycles the loaded bytes onto the active-low board LEDs.
module flash_loader_top #(
  parameter int          RAM_DEPTH_BITWIDTH = 4,
  parameter logic [23:0] FLASH_ADDR         = 24'h000000,
  parameter int          STARTUP_DELAY      = 16,
  parameter int          DISPLAY_SHIFT      = 22
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  output logic [5:0] led,
  output logic       flash_clk,
  input  logic       flash_miso,
  output logic       flash_mosi,
  output logic       flash_cs
);

  localparam int          RAM_DEPTH = 2 ** RAM_DEPTH_BITWIDTH;
  localparam int          SW        = $clog2(STARTUP_DELAY + 1) + 1;
  localparam logic [31:0] CMD_WORD  = {8'h03, FLASH_ADDR};

  typedef enum logic [1:0] {STARTUP, CMD, READ, DONE} state_t;

  state_t                        r_state;
  logic [SW-1:0]                 r_cnt;
  logic                          r_phase;
  logic [4:0]                    r_bit;
  logic [31:0]                   r_shift;
  logic [2:0]                    r_rx_bit;
  logic [6:0]                    r_rx;
  logic [RAM_DEPTH_BITWIDTH-1:0] r_wr_idx;
  logic [RAM_DEPTH_BITWIDTH-1:0] r_disp_idx;
  logic [DISPLAY_SHIFT-1:0]      r_div;
  logic                          r_cs;
  logic                          r_sck;
  logic                          r_mosi;
  logic [5:0]                    r_led;
  logic [31:0]                   clock_cycle;
  logic [7:0]                    r_ram [0:RAM_DEPTH-1];

  logic [7:0] w_rx_byte;
  logic       w_ram_we;
  logic [7:0] w_rd_byte;

  // The byte completes on the edge that ends phase B of its eighth bit.
  assign w_rx_byte = {r_rx, flash_miso};
  assign w_ram_we  = (r_state == READ) && r_phase && (r_rx_bit == 3'd7);
  assign w_rd_byte = r_ram[r_disp_idx];

  assign led        = r_led;
  assign flash_clk  = r_sck;
  assign flash_mosi = r_mosi;
  assign flash_cs   = r_cs;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      clock_cycle <= 32'd0;
    end else begin
      clock_cycle <= clock_cycle + 32'd1;
    end
  end

  // RAM is left out of reset so it maps onto plain memory.
  always_ff @(posedge sys_clk) begin
    if (w_ram_we) begin
      r_ram[r_wr_idx] <= w_rx_byte;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= STARTUP;
      r_cnt      <= '0;
      r_phase    <= 1'b0;
      r_bit      <= 5'd0;
      r_shift    <= 32'd0;
      r_rx_bit   <= 3'd0;
      r_rx       <= 7'd0;
      r_wr_idx   <= '0;
      r_disp_idx <= '0;
      r_div      <= '0;
      r_cs       <= 1'b1;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_led      <= 6'b111111;
    end else begin
      case (r_state)
        STARTUP: begin
          r_led <= 6'b111111;
          if (r_cnt == SW'(STARTUP_DELAY)) begin
            r_state  <= CMD;
            r_cs     <= 1'b0;
            r_sck    <= 1'b0;
            r_phase  <= 1'b0;
            r_bit    <= 5'd0;
            r_mosi   <= CMD_WORD[31];
            r_shift  <= {CMD_WORD[30:0], 1'b0};
          end else begin
            r_cnt <= r_cnt + SW'(1);
          end
        end

        CMD: begin
          r_led <= 6'b111111;
          if (!r_phase) begin
            r_sck   <= 1'b1;
            r_phase <= 1'b1;
          end else begin
            r_sck   <= 1'b0;
            r_phase <= 1'b0;
            // Move straight into data so the chip-select window has no gap.
            if (r_bit == 5'd31) begin
              r_state  <= READ;
              r_mosi   <= 1'b0;
              r_rx_bit <= 3'd0;
              r_wr_idx <= '0;
            end else begin
              r_bit   <= r_bit + 5'd1;
              r_mosi  <= r_shift[31];
              r_shift <= {r_shift[30:0], 1'b0};
            end
          end
        end

        READ: begin
          r_led  <= 6'b111111;
          r_mosi <= 1'b0;
          if (!r_phase) begin
            r_sck   <= 1'b1;
            r_phase <= 1'b1;
          end else begin
            r_sck    <= 1'b0;
            r_phase  <= 1'b0;
            r_rx     <= w_rx_byte[6:0];
            r_rx_bit <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) begin
              r_wr_idx <= r_wr_idx + 1'b1;
              if (&r_wr_idx) begin
                r_state    <= DONE;
                r_cs       <= 1'b1;
                r_disp_idx <= '0;
                r_div      <= '0;
              end
            end
          end
        end

        DONE: begin
          r_div <= r_div + 1'b1;
          if (&r_div) begin
            r_disp_idx <= r_disp_idx + 1'b1;
          end
          r_led <= ~w_rd_byte[5:0];
        end

        default: r_state <= STARTUP;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_loader_top.sv
// Directed bench for flash_loader_top: reset values, SPI framing, flash data
// capture into RAM and the LED display sequence, plus a mid-transfer reset.
module tb_flash_loader_top;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       flash_miso = 1'b0;
  logic [5:0] led;
  logic       flash_clk;
  logic       flash_mosi;
  logic       flash_cs;

  int n_checks = 0;
  int n_errors = 0;

  flash_loader_top #(
    .RAM_DEPTH_BITWIDTH(4),
    .FLASH_ADDR        (24'h000000),
    .STARTUP_DELAY     (16),
    .DISPLAY_SHIFT     (2)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .led       (led),
    .flash_clk (flash_clk),
    .flash_miso(flash_miso),
    .flash_mosi(flash_mosi),
    .flash_cs  (flash_cs)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // mode 1: flash line stuck high; mode 2: flash returns bytes 0x00..0x0F.
  // Releases reset, then observes n_cyc cycles (cycle k = after k-th edge).
  task automatic run_load(input int mode, input int n_cyc, input bit full);
    int          first_low = -1;
    int          low_cnt = 0;
    int          low_windows = 0;
    int          rises = 0;
    int          data_ones = 0;
    int          cc_bad = 0;
    int          led_bad = 0;
    logic [31:0] cmd_bits = 32'd0;
    logic        prev_cs = 1'b1;
    logic        prev_sck = 1'b0;
    logic [7:0]  byte_val;
    logic [5:0]  exp_led;
    int          j;
    int          idx;

    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int cyc = 1; cyc <= n_cyc; cyc++) begin
      @(negedge sys_clk);
      if (dut.clock_cycle != cyc) cc_bad++;
      if (!flash_cs) begin
        low_cnt++;
        if (first_low < 0) first_low = cyc;
        if (prev_cs) low_windows++;
      end
      if (flash_clk && !prev_sck) begin
        rises++;
        if (rises <= 32) cmd_bits = {cmd_bits[30:0], flash_mosi};
        else data_ones += int'(flash_mosi);
        // Present the next data bit; the DUT samples it at the end of phase B.
        if (mode == 1) begin
          flash_miso = 1'b1;
        end else if (rises > 32) begin
          j        = rises - 33;
          byte_val = 8'(j / 8);
          flash_miso = byte_val[7 - (j % 8)];
        end else begin
          flash_miso = 1'b0;
        end
      end
      if (cyc >= 338) begin
        idx      = ((cyc - 338) / 4) % 16;
        byte_val = 8'(idx);
        exp_led  = (mode == 1) ? 6'b000000 : ~byte_val[5:0];
        if (led !== exp_led) led_bad++;
      end
      if (cyc == 337) check("led_before_done", 32'(led), 32'h3F);
      if (mode == 1 && cyc == 338) check("led_ff_first", 32'(led), 32'h00);
      if (mode == 2 && cyc == 338) check("led_byte0", 32'(led), 32'h3F);
      if (mode == 2 && cyc == 342) check("led_byte1", 32'(led), 32'h3E);
      if (mode == 2 && cyc == 398) check("led_byte15", 32'(led), 32'h30);
      if (mode == 2 && cyc == 402) check("led_wrap0", 32'(led), 32'h3F);
      prev_cs  = flash_cs;
      prev_sck = flash_clk;
    end

    check("clock_cycle_track", 32'(cc_bad), 32'd0);
    if (full) begin
      check("cs_first_low", 32'(first_low), 32'd17);
      check("cs_low_cycles", 32'(low_cnt), 32'd320);
      check("cs_low_windows", 32'(low_windows), 32'd1);
      check("sck_rises", 32'(rises), 32'd160);
      check("cmd_word", cmd_bits, 32'h03000000);
      check("data_mosi_ones", 32'(data_ones), 32'd0);
      check("led_sequence", 32'(led_bad), 32'd0);
    end
    $display("load mode=%0d cycles=%0d cs_low=%0d sck_rises=%0d cmd=0x%08h led=0x%02h",
             mode, n_cyc, low_cnt, rises, cmd_bits, led);
  endtask

  initial begin
    sys_rst_n  = 1'b0;
    flash_miso = 1'b0;
    for (int t = 0; t < 3; t++) begin
      #33;
      check("rst_cs", 32'(flash_cs), 32'd1);
      check("rst_sck", 32'(flash_clk), 32'd0);
      check("rst_mosi", 32'(flash_mosi), 32'd0);
      check("rst_led", 32'(led), 32'h3F);
      check("rst_clock_cycle", dut.clock_cycle, 32'd0);
    end
    #1;

    run_load(1, 1000, 1'b1);

    sys_rst_n = 1'b0;
    #20;
    flash_miso = 1'b0;
    run_load(2, 1000, 1'b1);

    // Abort in the middle of the data phase.
    sys_rst_n = 1'b0;
    #20;
    run_load(2, 150, 1'b0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("abort_cs", 32'(flash_cs), 32'd1);
    check("abort_sck", 32'(flash_clk), 32'd0);
    check("abort_led", 32'(led), 32'h3F);
    check("abort_clock_cycle", dut.clock_cycle, 32'd0);
    #30;
    run_load(2, 1000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
